// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_display_ng bit-bang SPI master.
package spi_pkg;

    // State encoding for the frame sequencer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // SPI modes as {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Width of the half-bit phase counter for a W-bit word (counts 0..2W-1).
    function automatic int phase_width(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/spi_shift.sv
// W-bit shift register with selectable bit order. The head bit is always
// presented on serial_out so the first bit is valid straight after a load.
// With SPI_DISPLAY_READ_EN defined a separate receive register shifts in
// serial_in in the same bit order; rx_next exposes the value including the
// bit sampled this cycle so the word can be captured on its last sample.
module spi_shift #(
    parameter int W         = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    output logic         serial_out
`ifdef SPI_DISPLAY_READ_EN
    ,
    input  logic         sample_en,
    input  logic         serial_in,
    output logic [W-1:0] rx_next
`endif
);

    logic [W-1:0] tx_q;
    logic [W-1:0] tx_shifted;

    // Shift toward the output end chosen by the bit order.
    always_comb begin
        tx_shifted = tx_q;
        if (LSB_FIRST != 0) tx_shifted = {1'b0, tx_q[W-1:1]};
        else                tx_shifted = {tx_q[W-2:0], 1'b0};
    end

    // Transmit register: load has priority over shift.
    always_ff @(posedge clock) begin
        if (!reset_n)      tx_q <= '0;
        else if (load)     tx_q <= load_data;
        else if (shift_en) tx_q <= tx_shifted;
    end

    assign serial_out = (LSB_FIRST != 0) ? tx_q[0] : tx_q[W-1];

`ifdef SPI_DISPLAY_READ_EN
    logic [W-1:0] rx_q;

    // Next receive value; the first received bit ends up in the first-sent position.
    always_comb begin
        rx_next = rx_q;
        if (sample_en) begin
            if (LSB_FIRST != 0) rx_next = {serial_in, rx_q[W-1:1]};
            else                rx_next = {rx_q[W-2:0], serial_in};
        end
    end

    // Receive register.
    always_ff @(posedge clock) begin
        if (!reset_n) rx_q <= '0;
        else          rx_q <= rx_next;
    end
`endif

endmodule

// File: rtl/spi_display_ng.sv
// Bit-bang SPI master for display controllers, paced by a half-bit step strobe.
// Pops words from a first-word-fall-through source and serialises them.
// Optional read-back capture is built when SPI_DISPLAY_READ_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | cs released; pops and loads as soon as the source has a word
//   ST_SHIFT | clocking out a word, one half-bit per step (phase 0..2W-1)
//   ST_HOLD  | word done, nothing queued; cs held low until the next step
//   ST_GAP   | cs released; counts GAP steps before fetching again
module spi_display_ng
    import spi_pkg::*;
#(
    parameter int W         = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0,
    parameter int GAP       = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         step,
    input  logic         in_dc,
    input  logic [W-1:0] in_data,
    output logic         in_get,
    input  logic         in_empty,
    output logic         spi_cs_n,
    output logic         spi_clock,
    output logic         spi_dc,
    output logic         spi_mosi
`ifdef SPI_DISPLAY_READ_EN
    ,
    input  logic         spi_miso,
    output logic [W-1:0] rx_data,
    output logic         rx_valid
`endif
);

    localparam int              PW         = phase_width(W);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(2 * W - 1);
    localparam logic            IDLE_CLK   = (CPOL != 0);

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    gap_q, gap_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          dc_q, dc_d;
    logic          load, shift_en, end_word, serial_out;

    assign end_word = (state_q == ST_SHIFT) && step && (phase_q == LAST_PHASE);

    // Next-state and datapath control; the source is only popped in IDLE or at
    // the final step of a word so a back-to-back word never loses a step.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        dc_d     = dc_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!in_empty) begin
                    load    = 1'b1;
                    phase_d = '0;
                    cs_n_d  = 1'b0;
                    sclk_d  = IDLE_CLK;
                    dc_d    = in_dc;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (step) begin
                    phase_d = phase_q + 1'b1;
                    sclk_d  = phase_q[0] ? IDLE_CLK : !IDLE_CLK;
                    if (CPHA == 0) shift_en = phase_q[0] && (phase_q != LAST_PHASE);
                    else           shift_en = !phase_q[0] && (phase_q != '0);
                    if (end_word) begin
                        if (!in_empty) begin
                            load    = 1'b1;
                            phase_d = '0;
                            dc_d    = in_dc;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (step) begin
                    cs_n_d  = 1'b1;
                    gap_d   = 8'(GAP);
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (step) begin
                    gap_d = gap_q - 8'd1;
                    if (gap_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            gap_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= IDLE_CLK;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            dc_q    <= dc_d;
        end
    end

    assign in_get    = load && reset_n;
    assign spi_cs_n  = cs_n_q;
    assign spi_clock = sclk_q;
    assign spi_dc    = dc_q;
    assign spi_mosi  = !cs_n_q && serial_out;

`ifdef SPI_DISPLAY_READ_EN
    logic         sample_en;
    logic [W-1:0] rx_next;

    // MISO is sampled on the edge opposite the one that changes MOSI.
    assign sample_en = (state_q == ST_SHIFT) && step &&
                       ((CPHA == 0) ? !phase_q[0] : phase_q[0]);

    // Publish the received word on the final step of each word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= end_word;
            if (end_word) rx_data <= rx_next;
        end
    end
`endif

    spi_shift #(
        .W         (W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (load),
        .load_data  (in_data),
        .shift_en   (shift_en),
        .serial_out (serial_out)
`ifdef SPI_DISPLAY_READ_EN
        ,
        .sample_en  (sample_en),
        .serial_in  (spi_miso),
        .rx_next    (rx_next)
`endif
    );

endmodule

// File: tb/tb_spi_display_ng.sv
// Directed bench for spi_display_ng. Four instances:
//   0: W=8 mode 0 GAP=1 (own reset)   1: W=8 mode 3
//   2: W=9 LSB first                   3: W=8 mode 0 GAP=3
// Each is fed from a bench queue acting as a FWFT source; a negedge monitor
// records rising-edge MOSI samples, pops, and steps seen with cs low/high.
module tb_spi_display_ng;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       step = 1'b0;
    logic       rst_all = 1'b0;
    logic       rst0 = 1'b0;
    logic [3:0] in_empty, in_dc, in_get, cs_n, sclk, dc, mosi;
    logic [8:0] in_data [4];
    logic [9:0] q0[$], q1[$], q2[$], q3[$];

`ifdef SPI_DISPLAY_READ_EN
    logic [7:0] rx_data0, rx_data1, rx_data3;
    logic [8:0] rx_data2;
    logic [3:0] rx_valid;
`endif

    int pass_n = 0, total_n = 0;
    int step_total = 0, rxv_n = 0;
    int pops[4], last_pop[4], prev_pop[4], cs_low[4], hi_steps[4], hi_at_pop[4];
    int samp_n[4], viol[4];
    logic [31:0] acc[4];
    logic [3:0]  dc_first, dc_ninth, pclk, pmosi, pcs;

    spi_display_ng #(.W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .GAP(1)) dut0 (
        .clock(clock), .reset_n(rst0), .step(step), .in_dc(in_dc[0]),
        .in_data(in_data[0][7:0]), .in_get(in_get[0]), .in_empty(in_empty[0]),
        .spi_cs_n(cs_n[0]), .spi_clock(sclk[0]), .spi_dc(dc[0]), .spi_mosi(mosi[0])
`ifdef SPI_DISPLAY_READ_EN
        , .spi_miso(mosi[0]), .rx_data(rx_data0), .rx_valid(rx_valid[0])
`endif
    );

    spi_display_ng #(.W(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .GAP(1)) dut1 (
        .clock(clock), .reset_n(rst_all), .step(step), .in_dc(in_dc[1]),
        .in_data(in_data[1][7:0]), .in_get(in_get[1]), .in_empty(in_empty[1]),
        .spi_cs_n(cs_n[1]), .spi_clock(sclk[1]), .spi_dc(dc[1]), .spi_mosi(mosi[1])
`ifdef SPI_DISPLAY_READ_EN
        , .spi_miso(mosi[1]), .rx_data(rx_data1), .rx_valid(rx_valid[1])
`endif
    );

    spi_display_ng #(.W(9), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .GAP(1)) dut2 (
        .clock(clock), .reset_n(rst_all), .step(step), .in_dc(in_dc[2]),
        .in_data(in_data[2]), .in_get(in_get[2]), .in_empty(in_empty[2]),
        .spi_cs_n(cs_n[2]), .spi_clock(sclk[2]), .spi_dc(dc[2]), .spi_mosi(mosi[2])
`ifdef SPI_DISPLAY_READ_EN
        , .spi_miso(mosi[2]), .rx_data(rx_data2), .rx_valid(rx_valid[2])
`endif
    );

    spi_display_ng #(.W(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .GAP(3)) dut3 (
        .clock(clock), .reset_n(rst_all), .step(step), .in_dc(in_dc[3]),
        .in_data(in_data[3][7:0]), .in_get(in_get[3]), .in_empty(in_empty[3]),
        .spi_cs_n(cs_n[3]), .spi_clock(sclk[3]), .spi_dc(dc[3]), .spi_mosi(mosi[3])
`ifdef SPI_DISPLAY_READ_EN
        , .spi_miso(mosi[3]), .rx_data(rx_data3), .rx_valid(rx_valid[3])
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [9:0] qhead(input int d);
        case (d)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic qpop(input int d);
        case (d)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic qpush(input int d, input logic [9:0] e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic refresh();
        for (int d = 0; d < 4; d++) begin
            in_empty[d] = (qsize(d) == 0);
            if (qsize(d) != 0) {in_dc[d], in_data[d]} = qhead(d);
            else begin
                in_dc[d]   = 1'b0;
                in_data[d] = '0;
            end
        end
    endtask

    task automatic clr(input int d);
        pops[d] = 0; last_pop[d] = 0; prev_pop[d] = 0; cs_low[d] = 0;
        samp_n[d] = 0; acc[d] = 0; viol[d] = 0; hi_at_pop[d] = 0;
        if (d == 0) rxv_n = 0;
    endtask

    // Push one word just after a step so the load cycle itself carries no step.
    task automatic push(input int d, input logic dcv, input logic [8:0] data);
        int k = 0;
        do begin
            @(negedge clock); #1;
            k++;
        end while (!step && k < 10);
        @(posedge clock); #1;
        qpush(d, {dcv, data});
        refresh();
    endtask

    task automatic wait_pops(input int d, input int n);
        int k = 0;
        while (pops[d] < n && k < 400) begin
            @(negedge clock); #1;
            k++;
        end
        if (pops[d] < n) chk($sformatf("timeout_pop_d%0d", d), pops[d], n);
    endtask

    task automatic wait_cs(input int d, input logic v);
        int k = 0;
        while (cs_n[d] !== v && k < 400) begin
            @(negedge clock); #1;
            k++;
        end
        if (cs_n[d] !== v) chk($sformatf("timeout_cs_d%0d", d), cs_n[d], v);
    endtask

    task automatic wait_idle(input int d);
        wait_cs(d, 1'b0);
        wait_cs(d, 1'b1);
        repeat (16) @(negedge clock);
        #1;
    endtask

    // Step strobe: one clock wide every 4 clocks.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            step = (cyc % 4 == 0);
        end
    end

    // FWFT source: a word seen popped before an edge leaves the queue after it.
    initial begin
        logic [3:0] g;
        refresh();
        forever begin
            @(negedge clock);
            g = in_get;
            @(posedge clock); #1;
            for (int d = 0; d < 4; d++)
                if (g[d] && qsize(d) != 0) qpop(d);
            refresh();
        end
    end

    // Monitor.
    initial begin
        pclk = '0; pmosi = '0; pcs = '1; dc_first = '0; dc_ninth = '0;
        for (int d = 0; d < 4; d++) begin
            clr(d);
            hi_steps[d] = 0;
        end
        forever begin
            @(negedge clock);
            if (step) step_total++;
            for (int d = 0; d < 4; d++) begin
                if (in_get[d]) begin
                    pops[d]++;
                    prev_pop[d]  = last_pop[d];
                    last_pop[d]  = step_total;
                    hi_at_pop[d] = hi_steps[d];
                end
                if (step && !cs_n[d]) cs_low[d]++;
                if (cs_n[d]) begin
                    if (step) hi_steps[d]++;
                end else hi_steps[d] = 0;
                if (sclk[d] && !pclk[d]) begin
                    acc[d] = {acc[d][30:0], mosi[d]};
                    samp_n[d]++;
                    if (samp_n[d] == 1) dc_first[d] = dc[d];
                    if (samp_n[d] == 9) dc_ninth[d] = dc[d];
                end
                if (!cs_n[d] && !pcs[d] && mosi[d] != pmosi[d] && !(pclk[d] && !sclk[d]))
                    viol[d]++;
                pclk[d]  = sclk[d];
                pmosi[d] = mosi[d];
                pcs[d]   = cs_n[d];
            end
`ifdef SPI_DISPLAY_READ_EN
            if (rx_valid[0]) rxv_n++;
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic [7:0] exp_samples;
        logic       exp_dc;
    } vec_t;

    vec_t tbl [4];
    logic [3:0] exp_cpol;
    int pops_at;

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 8'hA5, 1'b1};
        tbl[1] = '{1'b0, 8'h3C, 8'h3C, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 8'h96, 8'h96, 1'b0};
        exp_cpol = 4'b0010;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_cs_n_d%0d", d), cs_n[d], 1'b1);
            chk($sformatf("rst_sclk_d%0d", d), sclk[d], exp_cpol[d]);
            chk($sformatf("rst_dc_d%0d", d), dc[d], 1'b0);
            chk($sformatf("rst_mosi_d%0d", d), mosi[d], 1'b0);
            chk($sformatf("rst_in_get_d%0d", d), in_get[d], 1'b0);
        end
        @(posedge clock); #1;
        rst_all = 1'b1;
        rst0    = 1'b1;
        for (int d = 0; d < 4; d++) clr(d);

        // Single words, mode 0.
        for (int i = 0; i < 4; i++) begin
            clr(0);
            push(0, tbl[i].dc, {1'b0, tbl[i].data});
            wait_pops(0, 1);
            wait_idle(0);
            chk($sformatf("v%0d_samples", i), acc[0][7:0], tbl[i].exp_samples);
            chk($sformatf("v%0d_nsamp", i), samp_n[0], 8);
            chk($sformatf("v%0d_dc", i), dc_first[0], tbl[i].exp_dc);
            chk($sformatf("v%0d_pops", i), pops[0], 1);
            chk($sformatf("v%0d_cs_low_steps", i), cs_low[0], 17);
`ifdef SPI_DISPLAY_READ_EN
            chk($sformatf("v%0d_rx_data", i), rx_data0, tbl[i].exp_samples);
            chk($sformatf("v%0d_rx_valid_n", i), rxv_n, 1);
`endif
        end

        // Back-to-back words.
        clr(0);
        push(0, 1'b0, 9'h02A);
        push(0, 1'b1, 9'h055);
        wait_pops(0, 2);
        wait_idle(0);
        chk("b2b_samples", acc[0][15:0], 16'h2A55);
        chk("b2b_nsamp", samp_n[0], 16);
        chk("b2b_cs_low_steps", cs_low[0], 33);
        chk("b2b_pops", pops[0], 2);
        chk("b2b_pop_spacing", last_pop[0] - prev_pop[0], 16);
        chk("b2b_dc_word1", dc_first[0], 1'b0);
        chk("b2b_dc_word2", dc_ninth[0], 1'b1);

        // Mode 3.
        clr(1);
        push(1, 1'b0, 9'h081);
        wait_pops(1, 1);
        wait_idle(1);
        chk("m3_samples", acc[1][7:0], 8'h81);
        chk("m3_nsamp", samp_n[1], 8);
        chk("m3_mosi_change_off_falling", viol[1], 0);
        chk("m3_idle_sclk", sclk[1], 1'b1);
        chk("m3_cs_low_steps", cs_low[1], 17);

        // LSB first, W=9.
        clr(2);
        push(2, 1'b1, 9'h101);
        wait_pops(2, 1);
        wait_idle(2);
        chk("lsb_101_samples", acc[2][8:0], 9'h101);
        chk("lsb_101_nsamp", samp_n[2], 9);
        clr(2);
        push(2, 1'b0, 9'h003);
        wait_pops(2, 1);
        wait_idle(2);
        chk("lsb_003_samples", acc[2][8:0], 9'h180);
        chk("lsb_003_nsamp", samp_n[2], 9);
        chk("lsb_cs_low_steps", cs_low[2], 19);

        // GAP=3 release between two words.
        clr(3);
        push(3, 1'b0, 9'h011);
        wait_pops(3, 1);
        wait_cs(3, 1'b0);
        wait_cs(3, 1'b1);
        push(3, 1'b1, 9'h022);
        wait_pops(3, 2);
        chk("gap_high_steps_at_pop", hi_at_pop[3], 3);
        wait_idle(3);
        chk("gap_samples", acc[3][15:0], 16'h1122);
        chk("gap_pops", pops[3], 2);
        chk("gap_cs_low_steps", cs_low[3], 34);

        // Reset mid-word after phase 5.
        clr(0);
        push(0, 1'b1, 9'h0C3);
        wait_pops(0, 1);
        push(0, 1'b0, 9'h05A);
        begin
            int k = 0;
            while ((step_total - last_pop[0]) < 6 && k < 200) begin
                @(negedge clock); #1;
                k++;
            end
            if ((step_total - last_pop[0]) < 6) chk("timeout_phase5", step_total - last_pop[0], 6);
        end
        @(posedge clock); #1;
        rst0 = 1'b0;
        @(posedge clock);
        @(negedge clock); #1;
        chk("midrst_cs_n", cs_n[0], 1'b1);
        chk("midrst_sclk", sclk[0], 1'b0);
        chk("midrst_mosi", mosi[0], 1'b0);
        chk("midrst_in_get", in_get[0], 1'b0);
        pops_at = pops[0];
        repeat (3) @(negedge clock);
        #1;
        chk("midrst_no_pop", pops[0], pops_at);
        chk("midrst_queue_kept", qsize(0), 1);
        @(posedge clock); #1;
        rst0 = 1'b1;
        clr(0);
        wait_pops(0, 1);
        wait_idle(0);
        chk("postrst_samples", acc[0][7:0], 8'h5A);
        chk("postrst_nsamp", samp_n[0], 8);
        chk("postrst_pops", pops[0], 1);
        chk("postrst_dc", dc_first[0], 1'b0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
